// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared widths and scheduler state type for the TCP TX flow scheduler
package tcp_pkg;

  localparam int FLOWID_W  = 4;
  localparam int NUM_FLOWS = 1 << FLOWID_W;

  typedef enum logic {
    DISPATCH    = 1'b0,
    WAIT_UPDATE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/tcp_tx_flow_sched_if.sv
// rtl/tcp_tx_flow_sched_if.sv - kick, dispatch and update handshakes of the TX flow scheduler
interface tcp_tx_flow_sched_if;
  import tcp_pkg::*;

  logic                app_sched_kick_val;
  logic [FLOWID_W-1:0] app_sched_kick_flowid;
  logic                sched_app_kick_rdy;
  logic                rx_sched_kick_val;
  logic [FLOWID_W-1:0] rx_sched_kick_flowid;
  logic                sched_rx_kick_rdy;
  logic                sched_tx_req_val;
  logic [FLOWID_W-1:0] sched_tx_req_flowid;
  logic                sched_tx_req_rdy;
  logic                sched_tx_update_val;
  logic [FLOWID_W-1:0] sched_tx_update_flowid;
  logic                sched_tx_update_requeue;
  logic                sched_tx_update_rdy;

  modport master (
    input  app_sched_kick_val, app_sched_kick_flowid,
    input  rx_sched_kick_val, rx_sched_kick_flowid,
    input  sched_tx_req_rdy,
    input  sched_tx_update_val, sched_tx_update_flowid, sched_tx_update_requeue,
    output sched_app_kick_rdy, sched_rx_kick_rdy,
    output sched_tx_req_val, sched_tx_req_flowid,
    output sched_tx_update_rdy
  );

  modport slave (
    output app_sched_kick_val, app_sched_kick_flowid,
    output rx_sched_kick_val, rx_sched_kick_flowid,
    output sched_tx_req_rdy,
    output sched_tx_update_val, sched_tx_update_flowid, sched_tx_update_requeue,
    input  sched_app_kick_rdy, sched_rx_kick_rdy,
    input  sched_tx_req_val, sched_tx_req_flowid,
    input  sched_tx_update_rdy
  );

endinterface

// File: rtl/tcp_tx_sched_fifo.sv
// rtl/tcp_tx_sched_fifo.sv - circular flow-ID FIFO with combinational head read
module tcp_tx_sched_fifo #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [ADDR_W:0]   o_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally at DEPTH because they are exactly ADDR_W bits wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/tcp_tx_flow_sched.sv
// rtl/tcp_tx_flow_sched.sv - per-flow kick dedup, round-robin kick arbitration and one-at-a-time dispatch
// Optional statistics counters are enabled with TCP_TX_SCHED_STATS_EN.
module tcp_tx_flow_sched
  import tcp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  tcp_tx_flow_sched_if.master bus
`ifdef TCP_TX_SCHED_STATS_EN
  ,
  output logic [31:0] sched_stat_dispatch_cnt,
  output logic [31:0] sched_stat_dedup_cnt,
  output logic [31:0] sched_stat_requeue_cnt
`endif
);

  sched_state_e         r_state;
  logic [FLOWID_W-1:0]  r_inflight;
  logic [NUM_FLOWS-1:0] r_queued;
  logic [NUM_FLOWS-1:0] r_rekick;
  logic                 r_rr;

  logic [FLOWID_W-1:0] w_head;
  logic [FLOWID_W:0]   w_count;
  logic                w_in_wait, w_upd_fire, w_requeue_now, w_upd_push, w_kick_stall;
  logic                w_app_req, w_rx_req, w_grant_app, w_grant_rx, w_kick_fire;
  logic [FLOWID_W-1:0] w_kick_flow, w_push_data;
  logic                w_kick_new, w_kick_rekick, w_kick_dup;
  logic                w_req_val, w_pop, w_push;

  assign w_in_wait     = (r_state == WAIT_UPDATE);
  assign w_upd_fire    = !rst && w_in_wait && bus.sched_tx_update_val;
  assign w_requeue_now = bus.sched_tx_update_requeue | r_rekick[r_inflight];
  assign w_upd_push    = w_upd_fire && w_requeue_now;
  // Kicks wait out the update cycle so a kick racing the queued-bit clear becomes a single push.
  assign w_kick_stall  = rst || (w_in_wait && bus.sched_tx_update_val);

  assign w_app_req   = bus.app_sched_kick_val && !w_kick_stall;
  assign w_rx_req    = bus.rx_sched_kick_val && !w_kick_stall;
  assign w_grant_app = w_app_req && (!w_rx_req || !r_rr);
  assign w_grant_rx  = w_rx_req && (!w_app_req || r_rr);
  assign w_kick_fire = w_grant_app || w_grant_rx;
  assign w_kick_flow = w_grant_app ? bus.app_sched_kick_flowid : bus.rx_sched_kick_flowid;

  assign w_kick_new    = w_kick_fire && !r_queued[w_kick_flow];
  assign w_kick_dup    = w_kick_fire && r_queued[w_kick_flow];
  assign w_kick_rekick = w_kick_dup && w_in_wait && (w_kick_flow == r_inflight);

  assign w_req_val   = !rst && !w_in_wait && (w_count != '0);
  assign w_pop       = w_req_val && bus.sched_tx_req_rdy;
  assign w_push      = w_upd_push || w_kick_new;
  assign w_push_data = w_upd_push ? r_inflight : w_kick_flow;

  assign bus.sched_app_kick_rdy  = w_grant_app;
  assign bus.sched_rx_kick_rdy   = w_grant_rx;
  assign bus.sched_tx_req_val    = w_req_val;
  assign bus.sched_tx_req_flowid = w_head;
  assign bus.sched_tx_update_rdy = !rst && w_in_wait;

  tcp_tx_sched_fifo #(
    .DATA_W (FLOWID_W),
    .ADDR_W (FLOWID_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DISPATCH;
      r_inflight <= '0;
      r_queued   <= '0;
      r_rekick   <= '0;
      r_rr       <= 1'b0;
    end else begin
      if ((!r_rr && w_grant_app) || (r_rr && w_grant_rx)) r_rr <= !r_rr;
      if (w_kick_new)    r_queued[w_kick_flow] <= 1'b1;
      if (w_kick_rekick) r_rekick[w_kick_flow] <= 1'b1;
      case (r_state)
        DISPATCH: begin
          if (w_pop) begin
            r_inflight <= w_head;
            r_state    <= WAIT_UPDATE;
          end
        end
        WAIT_UPDATE: begin
          if (w_upd_fire) begin
            if (!w_requeue_now) r_queued[r_inflight] <= 1'b0;
            r_rekick[r_inflight] <= 1'b0;
            r_state <= DISPATCH;
          end
        end
        default: r_state <= DISPATCH;
      endcase
    end
  end

  a_update_flow: assert property (@(posedge clk) disable iff (rst)
    (w_in_wait && bus.sched_tx_update_val) |-> (bus.sched_tx_update_flowid == r_inflight));

`ifdef TCP_TX_SCHED_STATS_EN
  logic [31:0] r_stat_dispatch, r_stat_dedup, r_stat_requeue;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_dispatch <= '0;
      r_stat_dedup    <= '0;
      r_stat_requeue  <= '0;
    end else begin
      if (w_pop)      r_stat_dispatch <= r_stat_dispatch + 32'd1;
      if (w_kick_dup) r_stat_dedup    <= r_stat_dedup + 32'd1;
      if (w_upd_push) r_stat_requeue  <= r_stat_requeue + 32'd1;
    end
  end

  assign sched_stat_dispatch_cnt = r_stat_dispatch;
  assign sched_stat_dedup_cnt    = r_stat_dedup;
  assign sched_stat_requeue_cnt  = r_stat_requeue;
`endif

endmodule

// File: tb/tb_tcp_tx_flow_sched.sv
// tb/tb_tcp_tx_flow_sched.sv - table-driven bench for the TCP TX flow scheduler
module tb_tcp_tx_flow_sched;
  import tcp_pkg::*;

  typedef logic [FLOWID_W-1:0] flow_t;

  typedef struct {
    logic  rst;
    logic  av;
    flow_t aid;
    logic  rv;
    flow_t rid;
    logic  qrdy;
    logic  uv;
    flow_t uid;
    logic  ureq;
    logic  e_qval;
    flow_t e_qid;
    logic  e_ardy;
    logic  e_rrdy;
    logic  e_urdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  tcp_tx_flow_sched_if u_if ();

`ifdef TCP_TX_SCHED_STATS_EN
  logic [31:0] st_disp, st_dedup, st_req;
`endif

  tcp_tx_flow_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
`ifdef TCP_TX_SCHED_STATS_EN
    ,
    .sched_stat_dispatch_cnt (st_disp),
    .sched_stat_dedup_cnt    (st_dedup),
    .sched_stat_requeue_cnt  (st_req)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int av, input int aid, input int rv, input int rid,
                              input int qrdy, input int uv, input int uid, input int ureq,
                              input int eqv, input int eqid, input int ear, input int err, input int eur);
    vec_t v;
    v.rst = r[0];     v.av = av[0];   v.aid = FLOWID_W'(aid);
    v.rv = rv[0];     v.rid = FLOWID_W'(rid);
    v.qrdy = qrdy[0]; v.uv = uv[0];   v.uid = FLOWID_W'(uid); v.ureq = ureq[0];
    v.e_qval = eqv[0]; v.e_qid = FLOWID_W'(eqid);
    v.e_ardy = ear[0]; v.e_rrdy = err[0]; v.e_urdy = eur[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst;
    u_if.app_sched_kick_val      = v.av;
    u_if.app_sched_kick_flowid   = v.aid;
    u_if.rx_sched_kick_val       = v.rv;
    u_if.rx_sched_kick_flowid    = v.rid;
    u_if.sched_tx_req_rdy        = v.qrdy;
    u_if.sched_tx_update_val     = v.uv;
    u_if.sched_tx_update_flowid  = v.uid;
    u_if.sched_tx_update_requeue = v.ureq;
    #1;
    check({tag, ".req_val"}, 32'(u_if.sched_tx_req_val), 32'(v.e_qval));
    if (v.e_qval) check({tag, ".req_flowid"}, 32'(u_if.sched_tx_req_flowid), 32'(v.e_qid));
    check({tag, ".app_rdy"}, 32'(u_if.sched_app_kick_rdy), 32'(v.e_ardy));
    check({tag, ".rx_rdy"}, 32'(u_if.sched_rx_kick_rdy), 32'(v.e_rrdy));
    check({tag, ".upd_rdy"}, 32'(u_if.sched_tx_update_rdy), 32'(v.e_urdy));
  endtask

  vec_t tbl[$];
  int   mark[5];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(tbl[i], $sformatf("row%0d", i));
  endtask

  initial begin
    u_if.app_sched_kick_val      = 1'b0;
    u_if.app_sched_kick_flowid   = '0;
    u_if.rx_sched_kick_val       = 1'b0;
    u_if.rx_sched_kick_flowid    = '0;
    u_if.sched_tx_req_rdy        = 1'b0;
    u_if.sched_tx_update_val     = 1'b0;
    u_if.sched_tx_update_flowid  = '0;
    u_if.sched_tx_update_requeue = 1'b0;

    //               rst av aid rv rid qr uv uid urq | qv qid ar rr ur
    // single kick of flow 5, dispatch, update without requeue
    mark[0] = tbl.size();
    tbl.push_back(mk(1, 1, 5, 1, 6, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // flow 3 kicked three times before dispatch
    mark[1] = tbl.size();
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 3, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    // both requesters kicking every cycle: alternating grants, app first
    mark[2] = tbl.size();
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2, 0, 0, 0, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2, 0, 0, 0, 0,  1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2, 0, 0, 0, 0,  1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2, 0, 0, 0, 0,  1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    // rekick of in-flight flow 7; kick stalled during the update cycle
    mark[3] = tbl.size();
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, 0,  0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 7, 0, 1, 7, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    mark[4] = tbl.size();

    run_rows(mark[0], mark[1]);
    check("s1.queued5", 32'(dut.r_queued[5]), 32'd0);
    check("s1.count", 32'(dut.w_count), 32'd0);

    run_rows(mark[1], mark[2]);
`ifdef TCP_TX_SCHED_STATS_EN
    check("s2.dispatch_cnt", st_disp, 32'd1);
    check("s2.dedup_cnt", st_dedup, 32'd2);
`endif

    run_rows(mark[2], mark[3]);

    run_rows(mark[3], mark[4]);
    check("s4.rekick7", 32'(dut.r_rekick[7]), 32'd0);
    check("s4.queued7", 32'(dut.r_queued[7]), 32'd0);
`ifdef TCP_TX_SCHED_STATS_EN
    check("s4.requeue_cnt", st_req, 32'd1);
`endif

    // fill every flow, dedup when full, two dispatch rounds across the pointer wrap
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "s5.rst");
    for (int i = 0; i < NUM_FLOWS; i++)
      apply(mk(0, 1, i, 0, 0, 0, 0, 0, 0,  (i != 0) ? 1 : 0, 0, 1, 0, 0), $sformatf("s5.kick%0d", i));
    apply(mk(0, 0, 0, 1, 4, 0, 0, 0, 0,  1, 0, 0, 1, 0), "s5.fullkick");
    check("s5.count_full", 32'(dut.w_count), 32'(NUM_FLOWS));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, i, 0, 0, 0), $sformatf("s5.r%0d.disp%0d", r, i));
        apply(mk(0, 0, 0, 0, 0, 0, 1, i, (r == 0) ? 1 : 0,  0, 0, 0, 0, 1), $sformatf("s5.r%0d.upd%0d", r, i));
      end
    end
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0), "s5.drained");
    check("s5.count_end", 32'(dut.w_count), 32'd0);

    // reset while in WAIT_UPDATE with four flows queued
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "s6.rst");
    for (int i = 0; i < 4; i++)
      apply(mk(0, 1, i, 0, 0, 0, 0, 0, 0,  (i != 0) ? 1 : 0, 0, 1, 0, 0), $sformatf("s6.kick%0d", i));
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0), "s6.disp0");
    apply(mk(1, 1, 9, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0), "s6.midrst");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0), "s6.post");
    check("s6.count", 32'(dut.w_count), 32'd0);
    apply(mk(0, 1, 9, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0), "s6.kick9");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 9, 0, 0, 0), "s6.disp9");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 0, 0, 1), "s6.upd9");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0), "s6.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcp_tx_flow_sched.md
Name: tcp_tx_flow_sched

Overview:
- Flow-level TX scheduler that feeds tcp_tx_ctrl through the sched_tx_req / sched_tx_update handshake pair.
- Collects "flow needs service" kicks from two requesters:
  - the app send path, on a send-buffer tail-pointer advance;
  - the RX path, on an ACK or window update.
- Deduplicates kicks per flow and queues flows in FIFO order.
- Dispatches one flow at a time, and requeues a flow on update if it still has work.

Parameters:
- FLOWID_W, FLOWID_W from tcp_pkg, flow ID width. The flow count is NUM_FLOWS = 2**FLOWID_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- app_sched_kick_val  in  1  app requester kick valid
- app_sched_kick_flowid  in  FLOWID_W  flow to kick
- sched_app_kick_rdy  out  1  kick accepted
- rx_sched_kick_val  in  1  RX requester kick valid
- rx_sched_kick_flowid  in  FLOWID_W  flow to kick
- sched_rx_kick_rdy  out  1  kick accepted
- sched_tx_req_val  out  1  flow offered to TX control
- sched_tx_req_flowid  out  FLOWID_W  offered flow
- sched_tx_req_rdy  in  1  TX control takes the flow
- sched_tx_update_val  in  1  TX control finished the flow
- sched_tx_update_flowid  in  FLOWID_W  finished flow (must equal the in-flight flow)
- sched_tx_update_requeue  in  1  flow still has unsent data
- sched_tx_update_rdy  out  1  update accepted

Behaviour:
- Storage:
  - queued[NUM_FLOWS] bitmap: flow is in the FIFO or in flight.
  - rekick[NUM_FLOWS] bitmap: a kick arrived while the flow was in flight.
  - Circular FIFO of depth NUM_FLOWS: rd_ptr and wr_ptr of FLOWID_W bits each, plus count of FLOWID_W+1 bits.
  - Pointers wrap modulo NUM_FLOWS.
  - A flow is never in the FIFO twice, so the FIFO cannot overflow. count==NUM_FLOWS is legal; when full, every kick is a dedup.
- Reset: both bitmaps and count are 0, pointers are 0, state is DISPATCH. All val outputs are 0 while rst is high; all rdy outputs are 0 during rst.
- State machine, two states:
  - DISPATCH: sched_tx_req_val = (count!=0); sched_tx_req_flowid = FIFO head (combinational read). On val&rdy: pop, latch inflight_flowid, go to WAIT_UPDATE. sched_tx_update_rdy = 0.
  - WAIT_UPDATE: sched_tx_req_val = 0; sched_tx_update_rdy = 1. On update_val:
    - requeue_now = update_requeue | rekick[inflight].
    - If requeue_now: push inflight to the FIFO tail; queued stays 1.
    - Otherwise: clear queued[inflight].
    - Always clear rekick[inflight].
    - Go to DISPATCH.
- FIFO write port (one push per cycle), priority from highest:
  1. update requeue;
  2. round-robin winner of app/rx.
- Kick arbitration:
  - Round-robin pointer rr_reg, reset value app-first; it flips only when the favoured port wins.
  - Only the winning port gets rdy=1 that cycle. Both rdy are 0 in any cycle where an update requeue pushes.
- Accepted kick for flow F:
  - If !queued[F]: push F, set queued[F].
  - Else if F==inflight and state==WAIT_UPDATE: set rekick[F].
  - Else: drop (already queued).
- Same-cycle hazards:
  - Kick for F while the update for F clears queued: the kick sees the pre-update bitmap, so it sets rekick, which must then be treated as a push. Requirement: resolve as a single push of F with queued[F]=1. Implemented by stalling kicks (rdy=0) in any cycle with update_val in WAIT_UPDATE.
  - Pop and push in the same cycle are allowed; count is unchanged.
- Latency:
  - A kick accepted in cycle t is offered on sched_tx_req no earlier than cycle t+1.
  - A requeued flow can be redispatched in the cycle after its update, behind earlier entries.
- sched_tx_update_flowid != inflight is a protocol error: assertion only, no recovery.

Optional Feature:
- Macro: TCP_TX_SCHED_STATS_EN.
- When defined:
  - Adds outputs sched_stat_dispatch_cnt (32), sched_stat_dedup_cnt (32) and sched_stat_requeue_cnt (32).
  - These are free-running wrapping counters, zeroed on rst. They increment on: tx_req handshake; dropped or rekicked kick; update with requeue_now.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- tcp_pkg holds FLOWID_W and a sched_state_e typedef {DISPATCH, WAIT_UPDATE}.
- One sub-module, tcp_tx_sched_fifo:
  - circular FIFO of FLOWID_W entries, depth parameterised;
  - push/pop/count, combinational head read.
- Bitmaps, arbitration and the FSM stay in the top.

Test Plan:
- Single app kick of flow 5 → req_val=1 next cycle with flowid 5; rdy=1 → update requeue=0 → queued[5]=0, FIFO empty, req_val=0.
- App kicks flow 3 three times before dispatch → exactly one dispatch of 3; with stats on, dedup_cnt=2.
- App and rx kick flows 1 and 2 every cycle, both valid → grants alternate, starting app-first; dispatch order is 1,2.
- Flow 7 in flight, rx kicks 7, then update requeue=0 → 7 is redispatched once; rekick[7] cleared afterwards.
- Kick all NUM_FLOWS flows in order 0..N-1 → count==NUM_FLOWS, further kicks deduped; dispatch order 0..N-1 with pointer wrap; update requeue=1 on each → order repeats.
- Assert rst mid-WAIT_UPDATE with 4 flows queued → next cycle: req_val=0, update_rdy=0, count=0; a new kick of flow 9 is dispatched normally.
